// File: rtl/span_rasterizer.sv
// span_rasterizer: expands horizontal span commands into per-pixel fragments
// for the rasterizer-to-writer FIFO, with Z stepped by a per-pixel increment.
// A flush command emits the all-ones flush token.
// Optional build macro SPAN_RAST_ZSAT_EN: Z stepping saturates at 0 and
// 32'hFFFF_FFFF instead of wrapping modulo 2^32.
`timescale 1ns/1ps

module span_rasterizer #(
    parameter int RAST_FBW_FIFO_LEN = 96,
    parameter int LINE_LEN          = 9,
    parameter int COL_LEN           = 10,
    parameter int MAX_COL           = 639,
    parameter int MAX_LINE          = 479
) (
    input  logic                           PLB_clk,
    input  logic                           reset,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic                           cmd_flush,
    input  logic [LINE_LEN-1:0]            cmd_line,
    input  logic [COL_LEN-1:0]             cmd_x0,
    input  logic [COL_LEN-1:0]             cmd_x1,
    input  logic [31:0]                    cmd_color,
    input  logic [31:0]                    cmd_z0,
    input  logic [31:0]                    cmd_dz,
    output logic [0:RAST_FBW_FIFO_LEN-1]   fifo_data,
    output logic                           fifo_wr_en,
    input  logic                           fifo_full,
    output logic                           busy
);

    typedef enum logic [1:0] {IDLE, SPAN, FLUSH} state_t;

    localparam logic [COL_LEN-1:0]  MAX_COL_C  = COL_LEN'(MAX_COL);
    localparam logic [LINE_LEN-1:0] MAX_LINE_C = LINE_LEN'(MAX_LINE);

    state_t              state_reg,   state_next;
    logic [LINE_LEN-1:0] line_reg,    line_next;
    logic [COL_LEN-1:0]  cur_col_reg, cur_col_next;
    logic [COL_LEN-1:0]  end_col_reg, end_col_next;
    logic [31:0]         color_reg,   color_next;
    logic [31:0]         cur_z_reg,   cur_z_next;
    logic [31:0]         dz_reg,      dz_next;

    logic [31:0]         z_step;
    logic                cmd_drop;
    logic [0:RAST_FBW_FIFO_LEN-1] fragment;

    // Handshake and write strobe depend only on state and FIFO full, so a
    // full flag arriving in the same cycle suppresses the pending write.
    assign cmd_ready  = (state_reg == IDLE);
    assign busy       = (state_reg != IDLE);
    assign fifo_wr_en = (state_reg != IDLE) && !fifo_full;

    // Line and column are zero-extended into 16-bit fields, so a fragment can
    // never collide with the all-ones flush token.
    assign fragment  = {16'(line_reg), 16'(cur_col_reg), color_reg, cur_z_reg};
    assign fifo_data = (state_reg == FLUSH) ? '1 : fragment;

    // Spans that start past the right edge, run backwards or sit below the
    // last visible line are consumed without producing fragments.
    assign cmd_drop = (cmd_x0 > cmd_x1) || (cmd_x0 > MAX_COL_C) || (cmd_line > MAX_LINE_C);

`ifdef SPAN_RAST_ZSAT_EN
    logic [32:0] z_sum;

    // Saturating Z step: a carry out of the sign-extended add means overflow
    // for a positive dz and a negative result for a negative dz.
    always_comb begin
        z_sum  = {1'b0, cur_z_reg} + {dz_reg[31], dz_reg};
        z_step = z_sum[31:0];
        if (z_sum[32]) begin
            z_step = dz_reg[31] ? 32'h0000_0000 : 32'hFFFF_FFFF;
        end
    end
`else
    // Wrapping Z step, modulo 2^32.
    always_comb begin
        z_step = cur_z_reg + dz_reg;
    end
`endif

    // State and span registers; reset aborts any span in progress.
    always_ff @(posedge PLB_clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            line_reg    <= '0;
            cur_col_reg <= '0;
            end_col_reg <= '0;
            color_reg   <= '0;
            cur_z_reg   <= '0;
            dz_reg      <= '0;
        end else begin
            state_reg   <= state_next;
            line_reg    <= line_next;
            cur_col_reg <= cur_col_next;
            end_col_reg <= end_col_next;
            color_reg   <= color_next;
            cur_z_reg   <= cur_z_next;
            dz_reg      <= dz_next;
        end
    end

    // Next-state logic: accept in IDLE, step one pixel per write in SPAN,
    // emit a single token in FLUSH; everything holds while the FIFO is full.
    always_comb begin
        state_next   = state_reg;
        line_next    = line_reg;
        cur_col_next = cur_col_reg;
        end_col_next = end_col_reg;
        color_next   = color_reg;
        cur_z_next   = cur_z_reg;
        dz_next      = dz_reg;
        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_flush) begin
                        state_next = FLUSH;
                    end else begin
                        line_next    = cmd_line;
                        cur_col_next = cmd_x0;
                        end_col_next = (cmd_x1 > MAX_COL_C) ? MAX_COL_C : cmd_x1;
                        color_next   = cmd_color;
                        cur_z_next   = cmd_z0;
                        dz_next      = cmd_dz;
                        state_next   = cmd_drop ? IDLE : SPAN;
                    end
                end
            end
            SPAN: begin
                if (!fifo_full) begin
                    if (cur_col_reg == end_col_reg) begin
                        state_next = IDLE;
                    end else begin
                        cur_col_next = cur_col_reg + 1'b1;
                        cur_z_next   = z_step;
                    end
                end
            end
            FLUSH: begin
                if (!fifo_full) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_span_rasterizer.sv
// tb_span_rasterizer: directed and randomized span/flush commands against a
// queue-based reference model that lists the expected fragments per command.
`timescale 1ns/1ps

module tb_span_rasterizer;

    logic        PLB_clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_flush;
    logic [8:0]  cmd_line;
    logic [9:0]  cmd_x0;
    logic [9:0]  cmd_x1;
    logic [31:0] cmd_color;
    logic [31:0] cmd_z0;
    logic [31:0] cmd_dz;
    logic [0:95] fifo_data;
    logic        fifo_wr_en;
    logic        fifo_full;
    logic        busy;

    int          errors = 0;
    int          checks = 0;
    int          writes = 0;
    logic        rand_full = 1'b0;
    logic [95:0] exp_q[$];

    span_rasterizer dut (
        .PLB_clk    (PLB_clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_flush  (cmd_flush),
        .cmd_line   (cmd_line),
        .cmd_x0     (cmd_x0),
        .cmd_x1     (cmd_x1),
        .cmd_color  (cmd_color),
        .cmd_z0     (cmd_z0),
        .cmd_dz     (cmd_dz),
        .fifo_data  (fifo_data),
        .fifo_wr_en (fifo_wr_en),
        .fifo_full  (fifo_full),
        .busy       (busy)
    );

    initial begin
        PLB_clk = 1'b0;
        forever #5 PLB_clk = ~PLB_clk;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected fragments for the command currently on the cmd_* inputs.
    task automatic model_push();
        int     last;
        longint zz;
        logic [31:0] z;
        if (cmd_flush) begin
            exp_q.push_back({96{1'b1}});
        end else if (!(cmd_x0 > cmd_x1 || cmd_x0 > 10'd639 || cmd_line > 9'd479)) begin
            last = (cmd_x1 > 10'd639) ? 639 : int'(cmd_x1);
            for (int c = int'(cmd_x0); c <= last; c++) begin
                zz = longint'(cmd_z0) + longint'(c - int'(cmd_x0)) * longint'($signed(cmd_dz));
`ifdef SPAN_RAST_ZSAT_EN
                if (zz < 0) zz = 0;
                if (zz > 64'sh0000_0000_FFFF_FFFF) zz = 64'sh0000_0000_FFFF_FFFF;
`endif
                z = zz[31:0];
                exp_q.push_back({16'(cmd_line), 16'(c), cmd_color, z});
            end
        end
    endtask

    // Negedge sample: scoreboard every write and police the full flag.
    task automatic step_neg();
        logic [95:0] e;
        @(negedge PLB_clk);
        if (fifo_full) check("no_write_when_full", 96'(fifo_wr_en), 96'(0));
        if (fifo_wr_en) begin
            writes++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 96'(exp_q.size()), 96'(1));
            end else begin
                e = exp_q.pop_front();
                check("fragment", fifo_data, e);
            end
        end
    endtask

    task automatic step_pos();
        @(posedge PLB_clk);
        #1;
        if (rand_full) fifo_full = ($urandom_range(0, 3) == 0);
    endtask

    task automatic send(input logic fl, input int line, input int x0, input int x1,
                        input logic [31:0] color, input logic [31:0] z0, input logic [31:0] dz);
        logic acc;
        acc       = 1'b0;
        cmd_flush = fl;
        cmd_line  = 9'(line);
        cmd_x0    = 10'(x0);
        cmd_x1    = 10'(x1);
        cmd_color = color;
        cmd_z0    = z0;
        cmd_dz    = dz;
        cmd_valid = 1'b1;
        for (int n = 0; n < 500 && !acc; n++) begin
            step_neg();
            if (cmd_ready) begin
                acc = 1'b1;
                model_push();
                $display("cmd flush=%0d line=%0d x0=%0d x1=%0d z0=%h dz=%h", fl, cmd_line, cmd_x0, cmd_x1, z0, dz);
            end
            step_pos();
        end
        if (!acc) check("accept_timeout", 96'(cmd_ready), 96'(1));
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int n = 0; n < 3000 && !done; n++) begin
            step_neg();
            done = !busy && (exp_q.size() == 0);
            step_pos();
        end
        if (!done) check("idle_timeout", 96'(busy), 96'(0));
    endtask

    initial begin
        int w0;
        int x0;
        int x1;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_flush = 1'b0;
        cmd_line  = '0;
        cmd_x0    = '0;
        cmd_x1    = '0;
        cmd_color = '0;
        cmd_z0    = '0;
        cmd_dz    = '0;
        fifo_full = 1'b0;
        repeat (3) @(posedge PLB_clk);
        #1 reset = 1'b0;

        // Reset state
        step_neg();
        check("rst_cmd_ready", 96'(cmd_ready), 96'(1));
        check("rst_busy", 96'(busy), 96'(0));
        check("rst_wr_en", 96'(fifo_wr_en), 96'(0));
        check("rst_data", fifo_data, 96'(0));
        step_pos();

        // Basic span: writes start the cycle after accept, back to back
        w0 = writes;
        send(1'b0, 5, 10, 13, 32'h00FF00FF, 32'd100, 32'd2);
        for (int i = 0; i < 4; i++) begin
            step_neg();
            check("basic_wr_en", 96'(fifo_wr_en), 96'(1));
            check("basic_ready_low", 96'(cmd_ready), 96'(0));
            check("basic_line_field", 96'(fifo_data[0:15]), 96'(5));
            step_pos();
        end
        step_neg();
        check("basic_ready_back", 96'(cmd_ready), 96'(1));
        step_pos();
        check("basic_count", 96'(writes - w0), 96'(4));

        // Backpressure during span cycles 2-4
        w0 = writes;
        send(1'b0, 5, 10, 13, 32'h00FF00FF, 32'd100, 32'd2);
        step_neg();
        step_pos();
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step_neg();
            check("stall_busy", 96'(busy), 96'(1));
            step_pos();
        end
        fifo_full = 1'b0;
        wait_idle();
        check("stall_count", 96'(writes - w0), 96'(4));

        // Clip at the right edge
        w0 = writes;
        send(1'b0, 7, 636, 800, 32'hCAFE0001, 32'd50, 32'hFFFF_FFFF);
        wait_idle();
        check("clip_count", 96'(writes - w0), 96'(4));
        send(1'b0, 7, 630, 700, 32'hCAFE0002, 32'd9, 32'd1);
        wait_idle();
        check("clip2_count", 96'(writes - w0), 96'(14));

        // Dropped commands
        w0 = writes;
        send(1'b0, 3, 5, 3, 32'h1, 32'h2, 32'h3);
        step_neg();
        check("drop_rev_ready", 96'(cmd_ready), 96'(1));
        step_pos();
        send(1'b0, 480, 1, 2, 32'h1, 32'h2, 32'h3);
        step_neg();
        check("drop_line_ready", 96'(cmd_ready), 96'(1));
        step_pos();
        send(1'b0, 0, 640, 700, 32'h1, 32'h2, 32'h3);
        step_neg();
        check("drop_col_ready", 96'(cmd_ready), 96'(1));
        step_pos();
        check("drop_count", 96'(writes - w0), 96'(0));

        // Single pixel span
        w0 = writes;
        send(1'b0, 479, 639, 639, 32'h0BAD_F00D, 32'h1234, 32'h7);
        wait_idle();
        check("single_count", 96'(writes - w0), 96'(1));

        // Flush, then flush while full
        w0 = writes;
        send(1'b1, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        wait_idle();
        check("flush_count", 96'(writes - w0), 96'(1));
        w0 = writes;
        fifo_full = 1'b1;
        send(1'b1, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step_neg();
            check("flush_hold_busy", 96'(busy), 96'(1));
            step_pos();
        end
        fifo_full = 1'b0;
        wait_idle();
        check("flush_full_count", 96'(writes - w0), 96'(1));

        // Z wrap or saturation
        send(1'b0, 9, 20, 22, 32'h5555_AAAA, 32'hFFFF_FFFE, 32'd3);
        wait_idle();
        send(1'b0, 9, 20, 24, 32'h5555_AAAB, 32'd4, 32'hFFFF_FFFD);
        wait_idle();

        // Reset after 3 of 8 fragments
        w0 = writes;
        send(1'b0, 11, 100, 107, 32'hDEAD_BEEF, 32'd1000, 32'd10);
        for (int n = 0; n < 50; n++) begin
            step_neg();
            if (writes == w0 + 3) break;
            step_pos();
        end
        check("rst_prefix_count", 96'(writes - w0), 96'(3));
        reset = 1'b1;
        exp_q.delete();
        step_pos();
        step_neg();
        check("midrst_wr_en", 96'(fifo_wr_en), 96'(0));
        check("midrst_busy", 96'(busy), 96'(0));
        check("midrst_ready", 96'(cmd_ready), 96'(1));
        step_pos();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step_neg();
            step_pos();
        end
        check("midrst_no_resume", 96'(writes - w0), 96'(3));

        // Randomized commands with random backpressure
        rand_full = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                send(1'b1, 0, 0, 0, 32'h0, 32'h0, 32'h0);
            end else begin
                x0 = $urandom_range(0, 660);
                x1 = x0 + $urandom_range(0, 12);
                if ($urandom_range(0, 5) == 0 && x0 > 0) x1 = x0 - 1;
                send(1'b0,
                     ($urandom_range(0, 7) == 0) ? $urandom_range(470, 511) : $urandom_range(0, 479),
                     x0, (x1 > 1023) ? 1023 : x1, $urandom,
                     ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom,
                     ($urandom_range(0, 2) == 0) ? $urandom : 32'($urandom_range(0, 200) - 100));
            end
        end
        rand_full = 1'b0;
        fifo_full = 1'b0;
        wait_idle();
        check("queue_drained", 96'(exp_q.size()), 96'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
